pipe_field_writer: RTL
======================

// Module: pipe_field_writer
// PURPOSE
//  Game-side producer of the packed pipe registers consumed by the VGA pipe renderer.
//  Owns two pipe slots: spawns pipes at the right screen edge, scrolls them left once per frame,
//  retires them off the left edge, and pulses score as each pipe passes the bird column.
//  Sits in the game controller; outputs feed the pipe display path directly.
// PARAMETERS
//  SCREEN_WIDTH     640  spawn x = SCREEN_WIDTH-1
//  PIPE_WIDTH       70   pipe width in pixels (right edge = left + PIPE_WIDTH)
//  GAP_HEIGHT       120  gap height written to every pipe
//  GAP_CENTER_MIN   140  gap center = GAP_CENTER_MIN + lfsr[7:0]
//  SCROLL_SPEED     2    pixels moved per frame_tick
//  SPAWN_INTERVAL   180  frame_ticks between spawn attempts
//  BIRD_X           160  bird column used for scoring
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   asynchronous, active-low reset
//  frame_tick   in   1   1-cycle pulse per frame (vblank)
//  start        in   1   1-cycle pulse: begin/restart game
//  collision    in   1   level: bird hit something
//  pipe_reg0    out  32  slot 0, packed pipe word
//  pipe_reg1    out  32  slot 1, packed pipe word
//  score_pulse  out  1   1-cycle pulse per pipe passed
//  running      out  1   high in RUN state
// BEHAVIOUR
//  - Pipe word: [31:28]=0, [27:18]=left edge (10b), [17:9]=gap center (9b), [8:0]=gap height (9b).
//    32'b0 = empty slot; live pipes always have height!=0, so never encode as 0.
//  - Reset (async, resetn=0): pipe_reg0/1=0, score_pulse=0, running=0, state IDLE, spawn_cnt=0,
//    lfsr=16'hACE1. Deassertion takes effect on next clk edge.
//  - FSM: IDLE -start-> RUN; RUN -collision-> FROZEN; FROZEN -start-> RUN; start in RUN ignored.
//    Entering RUN: both slots cleared, spawn_cnt=0, lfsr NOT reseeded.
//  - LFSR: 16b Fibonacci, taps 16,14,13,11, shifts every clk in every state (never all-zero).
//  - RUN, on frame_tick (results visible the cycle after the tick):
//    1. Each non-empty slot: if left < SCROLL_SPEED -> slot=0; else left -= SCROLL_SPEED.
//    2. Score: if old left+PIPE_WIDTH >= BIRD_X and new left+PIPE_WIDTH < BIRD_X (slot still live)
//       -> score_pulse=1 for exactly one cycle; two pipes crossing same tick -> still one pulse
//       (cannot occur with default parameters).
//    3. Spawn: if spawn_cnt==SPAWN_INTERVAL-1 -> write lowest-index empty slot (after step 1) with
//       left=SCREEN_WIDTH-1, center=GAP_CENTER_MIN+lfsr[7:0], height=GAP_HEIGHT, spawn_cnt=0.
//       No empty slot -> spawn_cnt holds at SPAWN_INTERVAL-1, retried next tick. Else spawn_cnt++.
//    So first pipe appears on the SPAWN_INTERVAL-th tick after start.
//  - collision and frame_tick same cycle: collision wins; no move, spawn or score that cycle.
//  - FROZEN/IDLE: slots hold value (frozen scene stays displayed), frame_tick ignored.
//  - Arithmetic: left/right computed 11b wide to avoid wrap; center/height 9b, no overflow
//    for GAP_CENTER_MIN+255 <= 511.
//  - score_pulse is registered; otherwise 0 every cycle.
// CONFIGURATION
//  - PIPE_SPEEDUP_EN defined: internal 3b pass counter; every 8th score_pulse increments scroll
//    step by 1 up to 2*SCROLL_SPEED; step and counter return to SCROLL_SPEED/0 on entering RUN.
//  - PIPE_SPEEDUP_EN undefined: step fixed at SCROLL_SPEED; no counter logic.
// TESTING
//  - Reset mid-RUN with live pipes -> all outputs 0 same cycle, running=0, stays IDLE until start.
//  - start, then 180 frame_ticks -> pipe_reg0 left=639, height=120, center in [140,395]; pipe_reg1=0.
//  - Pipe at left=4, speed 2: tick->2, tick->0, next tick -> slot=32'b0, no score.
//  - Pipe left=92 (right=162), BIRD_X=160: tick -> left=90, no pulse; tick -> left=88, score_pulse 1 cycle.
//  - Both slots full at spawn time -> no overwrite; spawn lands in first slot freed on a later tick.
//  - collision with frame_tick same cycle -> regs unchanged, running=0; start -> slots 0, running=1.

Source files
------------

// File: rtl/pipe_field_writer.sv
// pipe_field_writer: spawns, scrolls, retires and scores two packed pipe slots for the pipe renderer.
// Optional PIPE_SPEEDUP_EN: scroll step grows by 1 every 8 pipes passed, capped at 2*SCROLL_SPEED.
module pipe_field_writer #(
  parameter int SCREEN_WIDTH   = 640,
  parameter int PIPE_WIDTH     = 70,
  parameter int GAP_HEIGHT     = 120,
  parameter int GAP_CENTER_MIN = 140,
  parameter int SCROLL_SPEED   = 2,
  parameter int SPAWN_INTERVAL = 180,
  parameter int BIRD_X         = 160
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        collision,
  output logic [31:0] pipe_reg0,
  output logic [31:0] pipe_reg1,
  output logic        score_pulse,
  output logic        running
);
  localparam int CW = $clog2(SPAWN_INTERVAL + 1);
  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;
  state_t state;
  logic [CW-1:0] spawn_cnt, cnt_nxt;
  logic [15:0] lfsr;
  logic [10:0] step;
  logic [31:0] mov0, mov1, nxt0, nxt1, spawn_word;
  logic due, scored;
`ifdef PIPE_SPEEDUP_EN
  logic [2:0] pass_cnt;
  logic [10:0] step_q;
  assign step = step_q;
`else
  assign step = 11'(SCROLL_SPEED);
`endif
  function automatic logic [31:0] move(input logic [31:0] w, input logic [10:0] s);
    logic [10:0] l;
    l = {1'b0, w[27:18]};
    return (w == 32'b0 || l < s) ? 32'b0 : {4'b0, 10'(l - s), w[17:0]};
  endfunction
  // Only a pipe that survives the move can be counted as passed.
  function automatic logic passed(input logic [31:0] o, input logic [31:0] n);
    return o != 32'b0 && n != 32'b0 &&
           ({1'b0, o[27:18]} + 11'(PIPE_WIDTH)) >= 11'(BIRD_X) &&
           ({1'b0, n[27:18]} + 11'(PIPE_WIDTH)) <  11'(BIRD_X);
  endfunction
  always_comb begin
    mov0 = move(pipe_reg0, step);
    mov1 = move(pipe_reg1, step);
    due = spawn_cnt == CW'(SPAWN_INTERVAL - 1);
    spawn_word = {4'b0, 10'(SCREEN_WIDTH - 1), 9'(GAP_CENTER_MIN + int'(lfsr[7:0])), 9'(GAP_HEIGHT)};
    nxt0 = (due && mov0 == 32'b0) ? spawn_word : mov0;
    nxt1 = (due && mov0 != 32'b0 && mov1 == 32'b0) ? spawn_word : mov1;
    cnt_nxt = !due ? spawn_cnt + 1'b1 : (mov0 == 32'b0 || mov1 == 32'b0) ? '0 : spawn_cnt;
    scored = passed(pipe_reg0, mov0) | passed(pipe_reg1, mov1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      running     <= 1'b0;
      pipe_reg0   <= 32'b0;
      pipe_reg1   <= 32'b0;
      score_pulse <= 1'b0;
      spawn_cnt   <= '0;
      lfsr        <= 16'hACE1;
`ifdef PIPE_SPEEDUP_EN
      pass_cnt    <= 3'd0;
      step_q      <= 11'(SCROLL_SPEED);
`endif
    end else begin
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      score_pulse <= 1'b0;
      if (state != RUN && start) begin
        state     <= RUN;
        running   <= 1'b1;
        pipe_reg0 <= 32'b0;
        pipe_reg1 <= 32'b0;
        spawn_cnt <= '0;
`ifdef PIPE_SPEEDUP_EN
        pass_cnt  <= 3'd0;
        step_q    <= 11'(SCROLL_SPEED);
`endif
      end else if (state == RUN && collision) begin
        state   <= FROZEN;
        running <= 1'b0;
      end else if (state == RUN && frame_tick) begin
        pipe_reg0   <= nxt0;
        pipe_reg1   <= nxt1;
        spawn_cnt   <= cnt_nxt;
        score_pulse <= scored;
`ifdef PIPE_SPEEDUP_EN
        if (scored) begin
          pass_cnt <= pass_cnt + 3'd1;
          if (pass_cnt == 3'd7 && step_q < 11'(2 * SCROLL_SPEED)) step_q <= step_q + 11'd1;
        end
`endif
      end
    end
  end
endmodule
